hazard_stall_controller: RTL and testbench

Parametrised pipeline hazard controller that sits between the IF/ID and ID/EX stages of the in-order RISC-V pipeline.
- Detects load-use hazards, qualified by per-source "register used" flags, and holds the front end for a configurable number of memory-load cycles.
- Inserts a configurable number of bubbles after a branch misprediction, with flush taking priority over stall.
- Keeps saturating performance counters of stall and flush cycles.

---
 rtl/hazard_stall_controller.sv | 189 ++++++++++++++++++
 tb/tb_hazard_stall_controller.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller
// Front-end hazard control between IF/ID and ID/EX. It holds the PC and
// IF/ID on load-use hazards for LOAD_LATENCY cycles, flushes IF/ID for
// FLUSH_CYCLES cycles after a branch misprediction (flush beats stall), and
// keeps saturating stall/flush cycle counters.
module hazard_stall_controller #(
  parameter int REG_ADDR_W   = 5,
  parameter int LOAD_LATENCY = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] if_id_rs1,
  input  logic [REG_ADDR_W-1:0] if_id_rs2,
  input  logic                  if_id_rs1_used,
  input  logic                  if_id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_ex_rd,
  input  logic                  id_ex_mem_read,
  input  logic                  wrong_prediction,
  input  logic                  perf_clear,
  output logic                  pc_write_en,
  output logic                  if_id_write_en,
  output logic                  ctrl_select,
  output logic                  if_id_flush,
  output logic                  busy,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_cycles
);

  // The remaining-cycle counter must hold the longer of the two sequences.
  localparam int MAX_SEQ = (LOAD_LATENCY > FLUSH_CYCLES) ? LOAD_LATENCY : FLUSH_CYCLES;
  localparam int REM_W   = (MAX_SEQ < 1) ? 1 : $clog2(MAX_SEQ + 1);

  // The first cycle of each sequence is spent in RUN, so the multi-cycle
  // states only need to cover the remaining LATENCY-1 cycles.
  localparam logic [REM_W-1:0] STALL_RELOAD = REM_W'(LOAD_LATENCY - 1);
  localparam logic [REM_W-1:0] FLUSH_RELOAD = REM_W'(FLUSH_CYCLES - 1);
  localparam logic [REM_W-1:0] REM_ONE      = REM_W'(1);
  localparam bit MULTI_STALL = (LOAD_LATENCY > 1);
  localparam bit MULTI_FLUSH = (FLUSH_CYCLES > 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [REM_W-1:0] rem_reg, rem_next;

  logic rs1_hit;
  logic rs2_hit;
  logic haz;
  logic stall_evt;   // this cycle holds the front end
  logic flush_evt;   // this cycle squashes IF/ID

  // Load-use detection; x0 never creates a dependency, and a source field
  // only counts when the instruction actually reads it.
  assign rs1_hit = if_id_rs1_used && (if_id_rs1 == id_ex_rd);
  assign rs2_hit = if_id_rs2_used && (if_id_rs2 == id_ex_rd);
  assign haz     = id_ex_mem_read && (id_ex_rd != '0) && (rs1_hit || rs2_hit);

  // State and remaining-cycle register; reset abandons any sequence in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_RUN;
      rem_reg   <= '0;
    end else begin
      state_reg <= state_next;
      rem_reg   <= rem_next;
    end
  end

  // Next-state logic and per-cycle stall/flush classification.
  always_comb begin
    state_next = state_reg;
    rem_next   = rem_reg;
    stall_evt  = 1'b0;
    flush_evt  = 1'b0;

    case (state_reg)
      ST_RUN: begin
        if (wrong_prediction) begin
          flush_evt = 1'b1;
          if (MULTI_FLUSH) begin
            state_next = ST_FLUSH;
            rem_next   = FLUSH_RELOAD;
          end
        end else if (haz) begin
          stall_evt = 1'b1;
          if (MULTI_STALL) begin
            state_next = ST_STALL;
            rem_next   = STALL_RELOAD;
          end
        end
      end

      ST_STALL: begin
        if (wrong_prediction) begin
          // A misprediction abandons the stall and starts a fresh flush.
          flush_evt = 1'b1;
          if (MULTI_FLUSH) begin
            state_next = ST_FLUSH;
            rem_next   = FLUSH_RELOAD;
          end else begin
            state_next = ST_RUN;
            rem_next   = '0;
          end
        end else begin
          stall_evt = 1'b1;
          if (rem_reg <= REM_ONE) begin
            state_next = ST_RUN;
            rem_next   = '0;
          end else begin
            rem_next = rem_reg - REM_ONE;
          end
        end
      end

      ST_FLUSH: begin
        flush_evt = 1'b1;
        if (wrong_prediction) begin
          // Another misprediction restarts the bubble train.
          rem_next = FLUSH_RELOAD;
        end else if (rem_reg <= REM_ONE) begin
          state_next = ST_RUN;
          rem_next   = '0;
        end else begin
          rem_next = rem_reg - REM_ONE;
        end
      end

      default: begin
        state_next = ST_RUN;
        rem_next   = '0;
      end
    endcase
  end

  // Pipeline control outputs; held at normal values while reset is asserted.
  always_comb begin
    pc_write_en    = 1'b1;
    if_id_write_en = 1'b1;
    ctrl_select    = 1'b1;
    if_id_flush    = 1'b0;
    busy           = (state_reg != ST_RUN);
    if (!rst_n) begin
      busy = 1'b0;
    end else if (flush_evt) begin
      ctrl_select = 1'b0;
      if_id_flush = 1'b1;
    end else if (stall_evt) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      ctrl_select    = 1'b0;
    end
  end

  // Performance counters: index 0 counts stall cycles, index 1 flush cycles.
  logic [1:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_val [2];

  assign cnt_inc = {flush_evt, stall_evt};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_perf
      logic [CNT_W-1:0] cnt_reg;

      // Saturating counter; a clear request overrides a same-cycle increment.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (perf_clear) begin
          cnt_reg <= '0;
        end else if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end

      assign cnt_val[gi] = cnt_reg;
    end
  endgenerate

  assign stall_cycles = cnt_val[0];
  assign flush_cycles = cnt_val[1];

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller. Two instances share stimulus:
// dut_a (LOAD_LATENCY=1, FLUSH_CYCLES=1, CNT_W=16) and
// dut_b (LOAD_LATENCY=3, FLUSH_CYCLES=2, CNT_W=3 so saturation is reachable).
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_hazard_stall_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic       rs1_used = 1'b0, rs2_used = 1'b0, mem_read = 1'b0;
  logic       wp = 1'b0, pclr = 1'b0;

  logic        a_pc, a_ifid, a_ctrl, a_flush, a_busy;
  logic [15:0] a_stall, a_fcnt;
  logic        b_pc, b_ifid, b_ctrl, b_flush, b_busy;
  logic [2:0]  b_stall, b_fcnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_stall_controller #(.REG_ADDR_W(5), .LOAD_LATENCY(1), .FLUSH_CYCLES(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .if_id_rs1(rs1), .if_id_rs2(rs2), .if_id_rs1_used(rs1_used), .if_id_rs2_used(rs2_used),
    .id_ex_rd(rd), .id_ex_mem_read(mem_read), .wrong_prediction(wp), .perf_clear(pclr),
    .pc_write_en(a_pc), .if_id_write_en(a_ifid), .ctrl_select(a_ctrl), .if_id_flush(a_flush),
    .busy(a_busy), .stall_cycles(a_stall), .flush_cycles(a_fcnt)
  );

  hazard_stall_controller #(.REG_ADDR_W(5), .LOAD_LATENCY(3), .FLUSH_CYCLES(2), .CNT_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .if_id_rs1(rs1), .if_id_rs2(rs2), .if_id_rs1_used(rs1_used), .if_id_rs2_used(rs2_used),
    .id_ex_rd(rd), .id_ex_mem_read(mem_read), .wrong_prediction(wp), .perf_clear(pclr),
    .pc_write_en(b_pc), .if_id_write_en(b_ifid), .ctrl_select(b_ctrl), .if_id_flush(b_flush),
    .busy(b_busy), .stall_cycles(b_stall), .flush_cycles(b_fcnt)
  );

  // Stimulus helpers (drive only).
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic set_idle();
    rs1 = '0; rs2 = '0; rd = '0; rs1_used = 1'b0; rs2_used = 1'b0;
    mem_read = 1'b0; wp = 1'b0; pclr = 1'b0;
  endtask

  task automatic set_load_use_rs1();
    rd = 5'd5; mem_read = 1'b1; rs1 = 5'd5; rs1_used = 1'b1; rs2 = 5'd9; rs2_used = 1'b1;
  endtask

  // Let both FSMs drain, then zero the counters.
  task automatic settle_and_clear();
    next_cycle(); set_idle();
    repeat (4) next_cycle();
    pclr = 1'b1;
    next_cycle(); pclr = 1'b0;
  endtask

  task automatic test_reset();
    set_load_use_rs1(); wp = 1'b0;
    repeat (2) next_cycle();
    #1;
    n_checks++; if (a_pc !== 1'b1) begin n_fail++; $display("FAIL reset_a_pc: got %b expected 1", a_pc); end
    n_checks++; if (a_ctrl !== 1'b1) begin n_fail++; $display("FAIL reset_a_ctrl: got %b expected 1", a_ctrl); end
    n_checks++; if (b_ifid !== 1'b1 || b_flush !== 1'b0 || b_busy !== 1'b0) begin n_fail++; $display("FAIL reset_b_ctrl: got ifid=%b flush=%b busy=%b expected 1 0 0", b_ifid, b_flush, b_busy); end
    n_checks++; if (a_stall !== 16'd0 || b_fcnt !== 3'd0) begin n_fail++; $display("FAIL reset_counters: got %0d %0d expected 0 0", a_stall, b_fcnt); end
    next_cycle(); set_idle(); rst_n = 1'b1;
    next_cycle(); #1;
    n_checks++; if (b_busy !== 1'b0 || b_pc !== 1'b1) begin n_fail++; $display("FAIL reset_release: got busy=%b pc=%b expected 0 1", b_busy, b_pc); end
    $display("test_reset done");
  endtask

  task automatic test_single_stall();
    settle_and_clear();
    set_load_use_rs1(); #1;
    n_checks++; if (a_pc !== 1'b0 || a_ctrl !== 1'b0 || a_ifid !== 1'b0) begin n_fail++; $display("FAIL single_stall_out: got pc=%b ctrl=%b ifid=%b expected 0 0 0", a_pc, a_ctrl, a_ifid); end
    n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL single_stall_busy: got %b expected 0", a_busy); end
    next_cycle(); set_idle(); #1;
    n_checks++; if (a_pc !== 1'b1 || a_ctrl !== 1'b1) begin n_fail++; $display("FAIL single_stall_after: got pc=%b ctrl=%b expected 1 1", a_pc, a_ctrl); end
    n_checks++; if (a_stall !== 16'd1) begin n_fail++; $display("FAIL single_stall_cnt: got %0d expected 1", a_stall); end
    $display("test_single_stall done");
  endtask

  task automatic test_multi_stall();
    settle_and_clear();
    set_load_use_rs1(); #1;
    n_checks++; if (b_pc !== 1'b0 || b_busy !== 1'b0) begin n_fail++; $display("FAIL multi_c1: got pc=%b busy=%b expected 0 0", b_pc, b_busy); end
    next_cycle(); #1;
    n_checks++; if (b_pc !== 1'b0 || b_ctrl !== 1'b0 || b_busy !== 1'b1) begin n_fail++; $display("FAIL multi_c2: got pc=%b ctrl=%b busy=%b expected 0 0 1", b_pc, b_ctrl, b_busy); end
    next_cycle(); #1;
    n_checks++; if (b_ifid !== 1'b0 || b_busy !== 1'b1) begin n_fail++; $display("FAIL multi_c3: got ifid=%b busy=%b expected 0 1", b_ifid, b_busy); end
    next_cycle(); set_idle(); #1;
    n_checks++; if (b_pc !== 1'b1 || b_busy !== 1'b0 || b_ctrl !== 1'b1) begin n_fail++; $display("FAIL multi_c4: got pc=%b busy=%b ctrl=%b expected 1 0 1", b_pc, b_busy, b_ctrl); end
    n_checks++; if (b_stall !== 3'd3 || b_fcnt !== 3'd0) begin n_fail++; $display("FAIL multi_cnt: got stall=%0d flush=%0d expected 3 0", b_stall, b_fcnt); end
    $display("test_multi_stall done");
  endtask

  task automatic test_no_hazard();
    settle_and_clear();
    // rd = x0 with matching rs1 and rs2
    rd = 5'd0; mem_read = 1'b1; rs1 = 5'd0; rs1_used = 1'b1; rs2 = 5'd0; rs2_used = 1'b1; #1;
    n_checks++; if (a_pc !== 1'b1 || a_ctrl !== 1'b1 || b_busy !== 1'b0) begin n_fail++; $display("FAIL no_haz_x0: got pc=%b ctrl=%b busy=%b expected 1 1 0", a_pc, a_ctrl, b_busy); end
    // rs2 matches but is not used
    next_cycle(); rd = 5'd7; rs2 = 5'd7; rs2_used = 1'b0; rs1 = 5'd3; rs1_used = 1'b1; #1;
    n_checks++; if (b_pc !== 1'b1 || b_ctrl !== 1'b1 || b_ifid !== 1'b1) begin n_fail++; $display("FAIL no_haz_unused: got pc=%b ctrl=%b ifid=%b expected 1 1 1", b_pc, b_ctrl, b_ifid); end
    // rs1 matches a non-load
    next_cycle(); mem_read = 1'b0; rs1 = 5'd7; #1;
    n_checks++; if (a_pc !== 1'b1) begin n_fail++; $display("FAIL no_haz_noload: got pc=%b expected 1", a_pc); end
    next_cycle(); set_idle(); #1;
    n_checks++; if (a_stall !== 16'd0 || b_stall !== 3'd0 || b_busy !== 1'b0) begin n_fail++; $display("FAIL no_haz_cnt: got a=%0d b=%0d busy=%b expected 0 0 0", a_stall, b_stall, b_busy); end
    // rs2 match with rs2_used = 1 is a hazard
    rd = 5'd7; mem_read = 1'b1; rs2 = 5'd7; rs2_used = 1'b1; rs1 = 5'd3; rs1_used = 1'b1; #1;
    n_checks++; if (a_pc !== 1'b0 || a_ctrl !== 1'b0) begin n_fail++; $display("FAIL rs2_haz: got pc=%b ctrl=%b expected 0 0", a_pc, a_ctrl); end
    $display("test_no_hazard done");
  endtask

  task automatic test_stall_then_flush();
    settle_and_clear();
    set_load_use_rs1(); #1;
    n_checks++; if (b_pc !== 1'b0 || b_flush !== 1'b0) begin n_fail++; $display("FAIL sf_c1: got pc=%b flush=%b expected 0 0", b_pc, b_flush); end
    next_cycle(); wp = 1'b1; #1;
    n_checks++; if (b_flush !== 1'b1 || b_pc !== 1'b1 || b_ifid !== 1'b1 || b_ctrl !== 1'b0) begin n_fail++; $display("FAIL sf_c2: got flush=%b pc=%b ifid=%b ctrl=%b expected 1 1 1 0", b_flush, b_pc, b_ifid, b_ctrl); end
    next_cycle(); set_idle(); #1;
    n_checks++; if (b_flush !== 1'b1 || b_busy !== 1'b1 || b_pc !== 1'b1) begin n_fail++; $display("FAIL sf_c3: got flush=%b busy=%b pc=%b expected 1 1 1", b_flush, b_busy, b_pc); end
    next_cycle(); #1;
    n_checks++; if (b_flush !== 1'b0 || b_busy !== 1'b0 || b_ctrl !== 1'b1) begin n_fail++; $display("FAIL sf_c4: got flush=%b busy=%b ctrl=%b expected 0 0 1", b_flush, b_busy, b_ctrl); end
    n_checks++; if (b_stall !== 3'd1 || b_fcnt !== 3'd2) begin n_fail++; $display("FAIL sf_cnt: got stall=%0d flush=%0d expected 1 2", b_stall, b_fcnt); end
    $display("test_stall_then_flush done");
  endtask

  task automatic test_simultaneous();
    settle_and_clear();
    set_load_use_rs1(); wp = 1'b1; #1;
    n_checks++; if (a_flush !== 1'b1 || a_pc !== 1'b1 || a_ifid !== 1'b1 || a_ctrl !== 1'b0) begin n_fail++; $display("FAIL simul_out: got flush=%b pc=%b ifid=%b ctrl=%b expected 1 1 1 0", a_flush, a_pc, a_ifid, a_ctrl); end
    next_cycle(); set_idle(); #1;
    n_checks++; if (a_stall !== 16'd0 || a_fcnt !== 16'd1) begin n_fail++; $display("FAIL simul_cnt: got stall=%0d flush=%0d expected 0 1", a_stall, a_fcnt); end
    n_checks++; if (a_flush !== 1'b0 || a_busy !== 1'b0) begin n_fail++; $display("FAIL simul_a_after: got flush=%b busy=%b expected 0 0", a_flush, a_busy); end
    n_checks++; if (b_flush !== 1'b1 || b_busy !== 1'b1 || b_stall !== 3'd0) begin n_fail++; $display("FAIL simul_b_after: got flush=%b busy=%b stall=%0d expected 1 1 0", b_flush, b_busy, b_stall); end
    $display("test_simultaneous done");
  endtask

  task automatic test_reset_mid_stall();
    settle_and_clear();
    set_load_use_rs1();
    next_cycle(); #1;
    n_checks++; if (b_busy !== 1'b1 || b_pc !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pre: got busy=%b pc=%b expected 1 0", b_busy, b_pc); end
    #1 rst_n = 1'b0; #1;
    n_checks++; if (b_pc !== 1'b1 || b_ctrl !== 1'b1 || b_busy !== 1'b0 || a_pc !== 1'b1) begin n_fail++; $display("FAIL rst_mid_out: got bpc=%b bctrl=%b bbusy=%b apc=%b expected 1 1 0 1", b_pc, b_ctrl, b_busy, a_pc); end
    n_checks++; if (b_stall !== 3'd0 || a_stall !== 16'd0) begin n_fail++; $display("FAIL rst_mid_cnt: got b=%0d a=%0d expected 0 0", b_stall, a_stall); end
    next_cycle(); set_idle(); rst_n = 1'b1;
    next_cycle(); #1;
    n_checks++; if (b_busy !== 1'b0 || b_pc !== 1'b1 || b_stall !== 3'd0) begin n_fail++; $display("FAIL rst_mid_release: got busy=%b pc=%b stall=%0d expected 0 1 0", b_busy, b_pc, b_stall); end
    $display("test_reset_mid_stall done");
  endtask

  task automatic test_saturation();
    settle_and_clear();
    // Continuous hazard: every cycle is a stall cycle in dut_b; 10 cycles
    // plus the 2 trailing cycles of the last sequence would wrap a 3-bit count.
    set_load_use_rs1();
    repeat (10) next_cycle();
    set_idle();
    repeat (4) next_cycle();
    #1;
    n_checks++; if (b_stall !== 3'd7) begin n_fail++; $display("FAIL saturate: got %0d expected 7", b_stall); end
    set_load_use_rs1();
    next_cycle(); set_idle(); #1;
    n_checks++; if (b_stall !== 3'd7) begin n_fail++; $display("FAIL saturate_hold: got %0d expected 7", b_stall); end
    $display("test_saturation done");
  endtask

  task automatic test_perf_clear();
    settle_and_clear();
    set_load_use_rs1();
    next_cycle(); set_idle(); #1;
    n_checks++; if (a_stall !== 16'd1) begin n_fail++; $display("FAIL pclr_pre: got %0d expected 1", a_stall); end
    set_load_use_rs1(); pclr = 1'b1; #1;
    n_checks++; if (a_pc !== 1'b0) begin n_fail++; $display("FAIL pclr_stall: got pc=%b expected 0", a_pc); end
    next_cycle(); set_idle(); #1;
    n_checks++; if (a_stall !== 16'd0) begin n_fail++; $display("FAIL pclr_wins: got %0d expected 0", a_stall); end
    $display("test_perf_clear done");
  endtask

  task automatic test_back_to_back();
    settle_and_clear();
    // dut_a: three back-to-back single-cycle stalls
    set_load_use_rs1();
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (a_pc !== 1'b0 || a_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_%0d: got pc=%b busy=%b expected 0 0", i, a_pc, a_busy); end
      next_cycle();
    end
    set_idle(); #1;
    n_checks++; if (a_stall !== 16'd3 || a_pc !== 1'b1) begin n_fail++; $display("FAIL b2b_stall_cnt: got cnt=%0d pc=%b expected 3 1", a_stall, a_pc); end
    settle_and_clear();
    // dut_b: misprediction during FLUSH restarts it
    wp = 1'b1;
    next_cycle(); #1;
    n_checks++; if (b_flush !== 1'b1 || b_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_flush_c2: got flush=%b busy=%b expected 1 1", b_flush, b_busy); end
    next_cycle(); wp = 1'b0; #1;
    n_checks++; if (b_flush !== 1'b1 || b_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_flush_c3: got flush=%b busy=%b expected 1 1", b_flush, b_busy); end
    next_cycle(); #1;
    n_checks++; if (b_flush !== 1'b0 || b_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_flush_c4: got flush=%b busy=%b expected 0 0", b_flush, b_busy); end
    n_checks++; if (b_fcnt !== 3'd3 || a_fcnt !== 16'd2) begin n_fail++; $display("FAIL b2b_flush_cnt: got b=%0d a=%0d expected 3 2", b_fcnt, a_fcnt); end
    $display("test_back_to_back done");
  endtask

  initial begin
    set_idle();
    test_reset();
    test_single_stall();
    test_multi_stall();
    test_no_hazard();
    test_stall_then_flush();
    test_simultaneous();
    test_reset_mid_stall();
    test_saturation();
    test_perf_clear();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
